// File: rtl/mem_responder.sv
// Single-port word memory behind a req/ready handshake with a fixed response latency.
// One transaction in flight; malformed requests are rejected with a one-cycle err pulse.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic               bad_c;
    logic               accept_c;
    logic               reject_c;
    logic               complete_c;

    logic [31:0] mem [DEPTH_WORDS];

    // Misaligned or past the end of the array
    assign bad_c = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH_WORDS));

    assign ready = (state_q == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept_c   = 1'b0;
        reject_c   = 1'b0;
        complete_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (bad_c) begin
                        reject_c = 1'b1;
                    end else begin
                        accept_c = 1'b1;
                        state_d  = BUSY;
                        cnt_d    = CNT_W'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    complete_c = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request fields captured at acceptance; later input changes are ignored
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else if (accept_c) begin
            we_q    <= we;
            idx_q   <= addr[IDX_W+1:2];
            wdata_q <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= complete_c;
            err    <= reject_c;
            if (complete_c && !we_q) begin
                rdata <= mem[idx_q];
            end
        end
    end

    // Array is not reset; a write lands on the same edge as its rvalid pulse
    always_ff @(posedge clk) begin
        if (complete_c && we_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=2 instance for the main scenarios,
// LATENCY=1 instance for back-to-back traffic against a small reference model.
module tb_mem_responder;

    logic        clk;
    logic        rst_n;

    logic        a_req, a_we;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        a_ready, a_rvalid, a_err;

    logic        b_req, b_we;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic        b_ready, b_rvalid, b_err;

    int          ntests = 0;
    int          nfail  = 0;
    logic [31:0] a_last_rd;
    logic [31:0] b_last_rd;
    logic [31:0] model [8];
    int          rv_count;
    int          j;
    int          rs;

    mem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut_a (
        .clk(clk), .reset(rst_n), .req(a_req), .we(a_we), .addr(a_addr), .wdata(a_wdata),
        .ready(a_ready), .rvalid(a_rvalid), .rdata(a_rdata), .err(a_err)
    );

    mem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) dut_b (
        .clk(clk), .reset(rst_n), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata),
        .ready(b_ready), .rvalid(b_rvalid), .rdata(b_rdata), .err(b_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic a_txn(input logic w, input logic [31:0] ad, input logic [31:0] d,
                         input logic [31:0] exp_rd, input string tag);
        int n;
        a_req   = 1'b1;
        a_we    = w;
        a_addr  = ad;
        a_wdata = d;
        tick;
        a_req = 1'b0;
        chk({tag, "_busy"}, 32'(a_ready), 32'd0);
        n = 0;
        while (a_rvalid !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd2);
        chk({tag, "_err"}, 32'(a_err), 32'd0);
        chk({tag, "_rdata"}, a_rdata, exp_rd);
        if (!w) a_last_rd = exp_rd;
    endtask

    task automatic a_reject(input logic [31:0] ad, input string tag);
        a_req   = 1'b1;
        a_we    = 1'b1;
        a_addr  = ad;
        a_wdata = 32'hBAD0BAD0;
        tick;
        a_req = 1'b0;
        chk({tag, "_err"}, 32'(a_err), 32'd1);
        chk({tag, "_ready"}, 32'(a_ready), 32'd1);
        chk({tag, "_rvalid"}, 32'(a_rvalid), 32'd0);
        tick;
        chk({tag, "_err_once"}, 32'(a_err), 32'd0);
        chk({tag, "_no_rvalid"}, 32'(a_rvalid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_ready", 32'(a_ready), 32'd1);
        chk("rst_rvalid", 32'(a_rvalid), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        chk("rst_rdata", a_rdata, 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd1);

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        a_last_rd = 32'd0;

        // first request right after reset release, then read back
        a_txn(1'b1, 32'h10, 32'hDEADBEEF, a_last_rd, "wr10");
        a_txn(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, "rd10");

        a_reject(32'h13, "mis13");
        a_reject(32'h100, "oor100");

        a_txn(1'b1, 32'hFC, 32'hCAFE0001, a_last_rd, "wrFC");
        a_txn(1'b0, 32'hFC, 32'h0, 32'hCAFE0001, "rdFC");
        a_txn(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, "rd10b");

        // busy-ignore: req held for five edges with changing fields
        a_txn(1'b1, 32'h44, 32'h0A0A0A44, a_last_rd, "pre44");
        a_txn(1'b1, 32'h48, 32'h0A0A0A48, a_last_rd, "pre48");
        a_req = 1'b1; a_we = 1'b1;
        a_addr = 32'h40; a_wdata = 32'h11111111;
        tick;
        chk("bi_e0_rvalid", 32'(a_rvalid), 32'd0);
        chk("bi_e0_ready", 32'(a_ready), 32'd0);
        a_addr = 32'h44; a_wdata = 32'h22222222;
        tick;
        chk("bi_e1_rvalid", 32'(a_rvalid), 32'd0);
        chk("bi_e1_err", 32'(a_err), 32'd0);
        a_addr = 32'h48; a_wdata = 32'h33333333;
        tick;
        chk("bi_e2_rvalid", 32'(a_rvalid), 32'd1);
        chk("bi_e2_ready", 32'(a_ready), 32'd1);
        a_addr = 32'h4C; a_wdata = 32'h44444444;
        tick;
        chk("bi_e3_rvalid", 32'(a_rvalid), 32'd0);
        chk("bi_e3_ready", 32'(a_ready), 32'd0);
        a_addr = 32'h50; a_wdata = 32'h55555555;
        tick;
        chk("bi_e4_rvalid", 32'(a_rvalid), 32'd0);
        chk("bi_e4_err", 32'(a_err), 32'd0);
        a_req = 1'b0;
        tick;
        chk("bi_e5_rvalid", 32'(a_rvalid), 32'd1);
        tick;
        chk("bi_e6_rvalid", 32'(a_rvalid), 32'd0);
        a_txn(1'b0, 32'h40, 32'h0, 32'h11111111, "bi_rd40");
        a_txn(1'b0, 32'h44, 32'h0, 32'h0A0A0A44, "bi_rd44");
        a_txn(1'b0, 32'h48, 32'h0, 32'h0A0A0A48, "bi_rd48");
        a_txn(1'b0, 32'h4C, 32'h0, 32'h44444444, "bi_rd4C");

        // reset while a write is in flight
        a_txn(1'b1, 32'h20, 32'hAAAA5555, a_last_rd, "wr20");
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'h20; a_wdata = 32'h12345678;
        tick;
        a_req = 1'b0;
        chk("mr_busy", 32'(a_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mr_async_ready", 32'(a_ready), 32'd1);
        chk("mr_async_rvalid", 32'(a_rvalid), 32'd0);
        chk("mr_async_rdata", a_rdata, 32'd0);
        a_last_rd = 32'd0;
        b_last_rd = 32'd0;
        tick;
        tick;
        rst_n = 1'b1;
        rv_count = 0;
        for (int k = 0; k < 4; k++) begin
            tick;
            if (a_rvalid === 1'b1) rv_count++;
        end
        chk("mr_no_rvalid", 32'(rv_count), 32'd0);
        a_txn(1'b0, 32'h20, 32'h0, 32'hAAAA5555, "mr_rd20");

        // LATENCY=1 back-to-back alternating writes and reads
        b_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            j = i / 2;
            if ((i % 2) == 0) begin
                b_we     = 1'b1;
                b_addr   = 32'(4 * j);
                b_wdata  = 32'h5A000000 + 32'(j) * 32'h00010203;
                model[j] = b_wdata;
            end else begin
                rs        = ((j % 2) == 1) ? j : (j >> 1);
                b_we      = 1'b0;
                b_addr    = 32'(4 * rs);
                b_wdata   = 32'hFFFFFFFF;
                b_last_rd = model[rs];
            end
            tick;
            chk($sformatf("b%0d_mid_rvalid", i), 32'(b_rvalid), 32'd0);
            chk($sformatf("b%0d_mid_ready", i), 32'(b_ready), 32'd0);
            tick;
            chk($sformatf("b%0d_rvalid", i), 32'(b_rvalid), 32'd1);
            chk($sformatf("b%0d_rdata", i), b_rdata, b_last_rd);
            chk($sformatf("b%0d_err", i), 32'(b_err), 32'd0);
        end
        b_req = 1'b0;
        tick;
        chk("b_end_rvalid", 32'(b_rvalid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
